// File: rtl/gpio_arb.sv
// gpio_arb: two-master round-robin arbiter in front of a GPIO register port.
// Each transaction is IDLE latch -> one BUS access cycle -> one RESP ack cycle.
module gpio_arb #(
  parameter int DW = 32,
  parameter int AW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      m_req,
  input  logic [1:0]      m_we,
  input  logic [2*AW-1:0] m_addr,
  input  logic [2*DW-1:0] m_wd,
  output logic [1:0]      m_gnt,
  output logic [1:0]      m_ack,
  output logic [DW-1:0]   m_rd,
  output logic            busy,
  output logic [AW-1:0]   gpio_a,
  output logic            gpio_we,
  output logic [DW-1:0]   gpio_wd,
  input  logic [DW-1:0]   gpio_rd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [DW-1:0] rd_q, rd_d;
  logic          win;
  logic [1:0]    own_oh;

  // Tie goes to the master not granted last; a lone requester wins
  always_comb begin
    win = (m_req == 2'b11) ? ~last_q : m_req[1];
  end

  // Next-state: latch winner in IDLE, capture read data in BUS
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (|m_req) begin
          owner_d = win;
          we_d    = win ? m_we[1] : m_we[0];
          addr_d  = win ? m_addr[2*AW-1:AW]
                        : m_addr[AW-1:0];
          wd_d    = win ? m_wd[2*DW-1:DW]
                        : m_wd[DW-1:0];
          state_d = BUS;
        end
      end
      BUS: begin
        rd_d    = gpio_rd;
        state_d = RESP;
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
    end
  end

  assign own_oh  = owner_q ? 2'b10 : 2'b01;
  assign busy    = (state_q != IDLE);
  assign m_gnt   = busy ? own_oh : 2'b00;
  assign m_ack   = (state_q == RESP) ? own_oh : 2'b00;
  assign m_rd    = rd_q;
  assign gpio_a  = addr_q;
  assign gpio_wd = wd_q;
  assign gpio_we = (state_q == BUS) & we_q;

endmodule
